gate_bank: RTL and testbench



---
 rtl/gate_bank.sv | 137 +++++++++++++
 tb/tb_gate_bank.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bank.sv
// Registered eight-function bitwise unit with valid/ready flow control and a
// built-in truth-table sweep that walks the selected operation over all four input pairs.
module gate_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] op_count,
    output logic             dbg_state
);

    // Handshake: a transfer happens on any cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready, ready never on valid.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       sweep_op_q, sweep_op_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             sweep_done_q, sweep_done_d;

    logic slot_free;
    logic accept;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       f,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (f)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~(a & b);
            3'd3:    r = ~(a | b);
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    assign slot_free = ~out_valid_q | out_ready;
    assign in_ready  = (state_q == IDLE) & ~sweep_start & slot_free;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        sweep_op_d   = sweep_op_q;
        out_y_d      = out_y_q;
        out_valid_d  = out_valid_q;
        op_count_d   = op_count_q;
        sweep_done_d = 1'b0;

        if (out_valid_q & out_ready) begin
            op_count_d = op_count_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_y_d     = apply_op(op, in_a, in_b);
                    out_valid_d = 1'b1;
                end else if (slot_free) begin
                    out_valid_d = 1'b0;
                end
                if (sweep_start) begin
                    state_d    = SWEEP;
                    sweep_op_d = op;
                    k_d        = 2'd0;
                end
            end
            SWEEP: begin
                // k[1] drives every bit of a, k[0] every bit of b.
                if (slot_free) begin
                    out_y_d     = apply_op(sweep_op_q, {WIDTH{k_q[1]}}, {WIDTH{k_q[0]}});
                    out_valid_d = 1'b1;
                    k_d         = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d      = IDLE;
                        sweep_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= 2'd0;
            sweep_op_q   <= 3'd0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            op_count_q   <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            sweep_op_q   <= sweep_op_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            op_count_q   <= op_count_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign out_y      = out_y_q;
    assign out_valid  = out_valid_q;
    assign out_zero   = (out_y_q == '0);
    assign out_ones   = &out_y_q;
    assign sweep_busy = (state_q == SWEEP);
    assign sweep_done = sweep_done_q;
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_bank.sv
// Directed and randomized bench for gate_bank with a cycle-level reference
// model built from per-bit truth tables.
module tb_gate_bank;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic [CNT_W-1:0] op_count;
    logic             dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic             m_valid;
    logic [WIDTH-1:0] m_y;
    int               m_cnt;
    logic             m_busy;
    logic             m_done;
    int               m_k;
    logic [2:0]       m_sop;

    logic [WIDTH-1:0] exp_q[$];

    gate_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .op_count(op_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] f,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [3:0]       tt;
        logic [WIDTH-1:0] y;
        case (f)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0111;
            3'd3: tt = 4'b0001;
            3'd4: tt = 4'b0110;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < WIDTH; i++) y[i] = tt[{a[i], b[i]}];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_cnt   = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_k     = 0;
        m_sop   = 3'd0;
    endtask

    task automatic check_all();
        logic m_slot;
        m_slot = !m_valid || out_ready;
        chk("in_ready",   {31'd0, in_ready},   {31'd0, !m_busy && !sweep_start && m_slot});
        chk("out_valid",  {31'd0, out_valid},  {31'd0, m_valid});
        chk("out_y",      {24'd0, out_y},      {24'd0, m_y});
        chk("out_zero",   {31'd0, out_zero},   {31'd0, m_y == 0});
        chk("out_ones",   {31'd0, out_ones},   {31'd0, m_y == {WIDTH{1'b1}}});
        chk("sweep_busy", {31'd0, sweep_busy}, {31'd0, m_busy});
        chk("sweep_done", {31'd0, sweep_done}, {31'd0, m_done});
        chk("op_count",   {28'd0, op_count},   m_cnt);
        chk("dbg_state",  {31'd0, dbg_state},  {31'd0, m_busy});
    endtask

    task automatic model_step();
        logic slot, acc, start_ok, n_done;
        slot     = !m_valid || out_ready;
        acc      = in_valid && !m_busy && !sweep_start && slot;
        start_ok = !m_busy && sweep_start;
        n_done   = 1'b0;
        if (m_valid && out_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (acc) begin
            m_y     = ref_fn(op, in_a, in_b);
            m_valid = 1'b1;
        end else if (m_busy && slot) begin
            m_y     = ref_fn(m_sop, {WIDTH{m_k[1]}}, {WIDTH{m_k[0]}});
            m_valid = 1'b1;
            m_k     = m_k + 1;
            if (m_k == 4) begin
                m_busy = 1'b0;
                n_done = 1'b1;
            end
        end else if (slot) begin
            m_valid = 1'b0;
        end
        if (start_ok) begin
            m_busy = 1'b1;
            m_sop  = op;
            m_k    = 0;
        end
        m_done = n_done;
    endtask

    // One cycle: check outputs mid-cycle, advance the model, then step past the edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        op          = 3'd0;
        in_a        = '0;
        in_b        = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] dir_tbl[8];
    logic [WIDTH-1:0] sweep_tbl[4];
    logic [WIDTH-1:0] held_y;
    int               dones;

    initial begin
        dir_tbl   = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        sweep_tbl = '{8'hFF, 8'h00, 8'h00, 8'h00};
        rst       = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_zero",  {31'd0, out_zero},  32'd1);
        chk("rst_count", {28'd0, op_count},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // All eight operations back-to-back on F0/CC.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op       = 3'(i);
            in_a     = 8'hF0;
            in_b     = 8'hCC;
            tick();
            chk("dir_op", {24'd0, out_y}, {24'd0, dir_tbl[i]});
        end
        idle_inputs();
        tick();

        // NOR boundary: all-ones then a single cleared bit.
        in_valid = 1'b1; op = 3'd3; in_a = 8'h00; in_b = 8'h00;
        tick();
        chk("nor_ff",   {24'd0, out_y}, 32'hFF);
        chk("nor_ones", {31'd0, out_ones}, 32'd1);
        in_a = 8'h01;
        tick();
        chk("nor_fe",   {24'd0, out_y}, 32'hFE);
        chk("fe_zero",  {31'd0, out_zero}, 32'd0);
        chk("fe_ones",  {31'd0, out_ones}, 32'd0);
        idle_inputs();
        tick();

        // Stall for five cycles with operands offered.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd4; in_a = 8'h5A; in_b = 8'h0F;
        tick();
        held_y = 8'h55;
        in_a   = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_y",     {24'd0, out_y}, {24'd0, held_y});
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        tick();

        // Sweep with NOR, consumer always ready.
        op = 3'd3; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0; op = 3'd0; in_valid = 1'b1;
        tick();
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            chk("sweep_y", {24'd0, out_y}, {24'd0, sweep_tbl[i]});
            if (sweep_done) dones++;
            tick();
        end
        chk("sweep_dones", dones, 32'd1);
        idle_inputs();
        tick();

        // Reset mid-sweep while stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; in_a = 8'h11; in_b = 8'h22;
        tick();
        in_valid = 1'b0; sweep_start = 1'b1; op = 3'd5;
        tick();
        sweep_start = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        chk("arst_valid", {31'd0, out_valid},  32'd0);
        chk("arst_y",     {24'd0, out_y},      32'd0);
        chk("arst_busy",  {31'd0, sweep_busy}, 32'd0);
        chk("arst_count", {28'd0, op_count},   32'd0);
        chk("arst_ones",  {31'd0, out_ones},   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Counter wrap: 16 transfers on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; op = 3'($urandom_range(0, 7));
            in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
        end
        chk("cnt_15", {28'd0, op_count}, 32'd15);
        idle_inputs();
        tick();
        chk("cnt_wrap", {28'd0, op_count}, 32'd0);

        // Randomized traffic including occasional sweeps and back-pressure.
        for (int i = 0; i < 300; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            op          = 3'($urandom_range(0, 7));
            in_a        = 8'($urandom);
            in_b        = 8'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            sweep_start = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
